// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and helpers for the data-memory responder
package mips_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        ERR
    } state_e;

    // Word aligned and inside the DEPTH-word window starting at byte 0.
    function automatic logic addr_ok(input logic [WORD_W-1:0] addr, input int depth);
        logic [WORD_W-1:0] limit;
        limit = 32'(depth) << 2;
        return (addr[1:0] == 2'b00) && (addr < limit);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - datapath data-port bus between processor and responder
interface data_mem_responder_if;
    import mips_mem_pkg::*;

    logic              mem_req;
    logic              mem_write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] write_data;
    logic [WORD_W-1:0] read_data;
    logic              mem_ready;
    logic              mem_error;
    logic              stall;

    modport master (
        output mem_req, mem_write, addr, write_data,
        input  read_data, mem_ready, mem_error, stall
    );

    modport slave (
        input  mem_req, mem_write, addr, write_data,
        output read_data, mem_ready, mem_error, stall
    );

endinterface

// File: rtl/ram_1rw.sv
// rtl/ram_1rw.sv - single-port word RAM with synchronous write and registered read
module ram_1rw
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] rdata_q;

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated load/store responder with address error reporting
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e            state_d, state_q;
    logic [3:0]        count_d, count_q;
    logic [IDX_W-1:0]  idx_d, idx_q;
    logic [WORD_W-1:0] wdata_d, wdata_q;
    logic              write_d, write_q;

    logic              access;
    logic              acc_write;
    logic [IDX_W-1:0]  acc_idx;
    logic [WORD_W-1:0] acc_wdata;
    logic [WORD_W-1:0] rdata;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        access    = 1'b0;
        acc_write = write_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    idx_d   = bus.addr[IDX_W+1:2];
                    wdata_d = bus.write_data;
                    write_d = bus.mem_write;
                    if (!addr_ok(bus.addr, DEPTH)) begin
                        state_d = ERR;
                    end else if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the accepting edge is also the access edge.
                        state_d   = RESP;
                        access    = 1'b1;
                        acc_write = bus.mem_write;
                        acc_idx   = bus.addr[IDX_W+1:2];
                        acc_wdata = bus.write_data;
                    end else begin
                        state_d = WAIT;
                        count_d = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (count_q == 4'd0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    ram_1rw #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (access),
        .we    (acc_write),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (rdata)
    );

    assign bus.read_data = rdata;
    assign bus.mem_ready = (state_q == RESP) || (state_q == ERR);
    assign bus.mem_error = (state_q == ERR);
    assign bus.stall     = bus.mem_req & ~bus.mem_ready;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    data_mem_responder_if b2 ();
    data_mem_responder_if b0 ();

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        tbl [11];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic req, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            b2.mem_req = req; b2.mem_write = w; b2.addr = a; b2.write_data = d;
        end else begin
            b0.mem_req = req; b0.mem_write = w; b0.addr = a; b0.write_data = d;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? b2.mem_ready : b0.mem_ready;
    endfunction
    function automatic logic er(input int sel);
        return (sel == 0) ? b2.mem_error : b0.mem_error;
    endfunction
    function automatic logic stl(input int sel);
        return (sel == 0) ? b2.stall : b0.stall;
    endfunction
    function automatic logic [31:0] rdv(input int sel);
        return (sel == 0) ? b2.read_data : b0.read_data;
    endfunction

    // Reference: a word memory plus the last successful load value.
    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                              output logic err, output logic [31:0] rd);
        longint unsigned ua;
        ua  = longint'(a);
        err = !((ua % 4 == 0) && (ua < 4 * DEPTH));
        if (!err) begin
            if (w) model_mem[ua / 4] = d;
            else   model_rd = model_mem[ua / 4];
        end
        rd = model_rd;
    endtask

    task automatic access(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err, input logic [31:0] exp_rd, input string tag);
        int   wc;
        int   lat;
        int   n;
        int   stalls;
        logic got;
        wc     = (sel == 0) ? 2 : 0;
        lat    = exp_err ? 1 : wc + 1;
        stalls = 0;
        got    = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, w, a, d);
        for (n = 0; n < 20; n++) begin
            #1;
            if (stl(sel)) stalls++;
            @(posedge clk);
            @(negedge clk);
            if (rdy(sel)) begin
                got = 1'b1;
                break;
            end
            // Inputs after acceptance must be ignored.
            drive(sel, 1'b1, 1'($urandom), $urandom, $urandom);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no mem_ready within 20 cycles", tag);
            drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
            return;
        end
        chk({tag, " latency"}, 32'(n + 1), 32'(lat));
        chk({tag, " stall cycles"}, 32'(stalls), 32'(lat));
        chk({tag, " mem_error"}, 32'(er(sel)), 32'(exp_err));
        chk({tag, " read_data"}, rdv(sel), exp_rd);
        chk({tag, " stall at ready"}, 32'(stl(sel)), 32'h0);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " ready pulse width"}, 32'(rdy(sel)), 32'h0);
    endtask

    initial begin
        logic        e;
        logic [31:0] r;
        logic [31:0] a;
        int          kind;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h0000_0012, 32'h0,         1'b1, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
        tbl[6]  = '{1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[7]  = '{1'b1, 32'h0000_0100, 32'h1111_1111, 1'b1, 32'hCAFE_F00D};
        tbl[8]  = '{1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'hCAFE_F00D};
        tbl[9]  = '{1'b0, 32'h0000_0011, 32'h0,         1'b1, 32'hCAFE_F00D};
        tbl[10] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};

        // Reset with a request pending.
        reset = 1'b0;
        drive(0, 1'b1, 1'b1, 32'h10, 32'h5555_5555);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("reset read_data", b2.read_data, 32'h0);
        chk("reset mem_ready", 32'(b2.mem_ready), 32'h0);
        chk("reset mem_error", 32'(b2.mem_error), 32'h0);
        chk("reset stall follows req", 32'(b2.stall), 32'h1);
        chk("reset w0 read_data", b0.read_data, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            access(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_err, tbl[i].exp_rd,
                   $sformatf("vec%0d", i));
        end

        // Zero wait states with mem_req held high across two loads.
        access(1, 1'b1, 32'h0, 32'h11, 1'b0, 32'h0, "w0 store0");
        access(1, 1'b1, 32'h4, 32'h22, 1'b0, 32'h0, "w0 store4");
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
        #1 chk("w0 stall before accept", 32'(b0.stall), 32'h1);
        @(posedge clk); @(negedge clk);
        chk("w0 first ready", 32'(b0.mem_ready), 32'h1);
        chk("w0 first data", b0.read_data, 32'h11);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("w0 no double accept", 32'(b0.mem_ready), 32'h0);
        @(posedge clk); @(negedge clk);
        chk("w0 second ready", 32'(b0.mem_ready), 32'h1);
        chk("w0 second data", b0.read_data, 32'h22);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("w0 idle after", 32'(b0.mem_ready), 32'h0);

        // Fill the whole array, then random traffic against the model.
        model_rd = tbl[10].exp_rd;
        for (int i = 0; i < DEPTH; i++) begin
            a = 32'(i * 4);
            model_step(1'b1, a, $urandom, e, r);
            access(0, 1'b1, a, model_mem[i], e, r, $sformatf("fill%0d", i));
        end
        for (int i = 0; i < 40; i++) begin
            logic        w;
            logic [31:0] d;
            kind = int'($urandom_range(0, 9));
            if (kind < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (kind == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (kind == 8) a = 32'(4 * DEPTH) + ($urandom & 32'h0000_FFFC);
            else                a = $urandom | 32'h8000_0000;
            w = 1'($urandom);
            d = $urandom;
            model_step(w, a, d, e, r);
            access(0, w, a, d, e, r, $sformatf("rnd%0d", i));
        end

        // Reset one cycle into a store: the uncommitted write is lost.
        model_step(1'b1, 32'h20, 32'h0, e, r);
        access(0, 1'b1, 32'h20, 32'h0, e, r, "preload20");
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midreset read_data", b2.read_data, 32'h0);
        chk("midreset mem_ready", 32'(b2.mem_ready), 32'h0);
        chk("midreset mem_error", 32'(b2.mem_error), 32'h0);
        @(posedge clk); @(negedge clk);
        chk("midreset held ready", 32'(b2.mem_ready), 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        model_rd = 32'h0;
        model_step(1'b0, 32'h20, 32'h0, e, r);
        access(0, 1'b0, 32'h20, 32'h0, e, r, "after reset load20");
        model_step(1'b0, 32'h10, 32'h0, e, r);
        access(0, 1'b0, 32'h10, 32'h0, e, r, "persist load10");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
